// File: rtl/booth_divide_fsmd_if.sv
// Handshake/data bundle for the signed divider (enable / data_valid protocol).
// DIV_SATURATE_EN adds the overflow_o result flag.
interface booth_divide_fsmd_if #(
    parameter int DATA_SIZE = 8
);
    logic                 enable_i;
    logic [DATA_SIZE-1:0] dividend_i;
    logic [DATA_SIZE-1:0] divisor_i;
    logic                 data_valid_o;
    logic [DATA_SIZE-1:0] quotient_o;
    logic [DATA_SIZE-1:0] remainder_o;
    logic                 div_by_zero_o;
`ifdef DIV_SATURATE_EN
    logic                 overflow_o;

    modport master (
        output enable_i, dividend_i, divisor_i,
        input  data_valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o
    );

    modport slave (
        input  enable_i, dividend_i, divisor_i,
        output data_valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o
    );
`else
    modport master (
        output enable_i, dividend_i, divisor_i,
        input  data_valid_o, quotient_o, remainder_o, div_by_zero_o
    );

    modport slave (
        input  enable_i, dividend_i, divisor_i,
        output data_valid_o, quotient_o, remainder_o, div_by_zero_o
    );
`endif
endinterface

// File: rtl/booth_divide_fsmd.sv
// Multi-cycle signed restoring divider: quotient truncates toward zero, remainder follows dividend.
// Optional macro DIV_SATURATE_EN saturates -2^(N-1) / -1 and raises overflow_o.
module booth_divide_fsmd #(
    parameter int DATA_SIZE = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    booth_divide_fsmd_if.slave  bus
);
    localparam int N     = DATA_SIZE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        SIGN   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic [N:0]       dvd_q, dvd_d;
    logic [N:0]       dsr_q, dsr_d;
    logic [N:0]       rem_q, rem_d;
    logic [N:0]       quo_q, quo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     quotient_q, quotient_d;
    logic [N-1:0]     remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
`ifdef DIV_SATURATE_EN
    logic             ovf_q, ovf_d;
`endif

    logic [N:0]   dividend_ext, divisor_ext;
    logic [N:0]   dividend_abs, divisor_abs;
    logic [N:0]   rem_shift;
    logic [N+1:0] trial;
    logic         trial_ok;
    logic [N:0]   quo_neg, rem_neg;

    // Magnitudes are one bit wider so that |-2^(N-1)| is representable.
    always_comb begin
        dividend_ext = {bus.dividend_i[N-1], bus.dividend_i};
        divisor_ext  = {bus.divisor_i[N-1], bus.divisor_i};
        dividend_abs = bus.dividend_i[N-1] ? (~dividend_ext + (N+1)'(1)) : dividend_ext;
        divisor_abs  = bus.divisor_i[N-1]  ? (~divisor_ext  + (N+1)'(1)) : divisor_ext;
        rem_shift    = {rem_q[N-1:0], dvd_q[N-1]};
        trial        = {1'b0, rem_shift} - {1'b0, dsr_q};
        trial_ok     = ~trial[N+1];
        quo_neg      = ~quo_q + (N+1)'(1);
        rem_neg      = ~rem_q + (N+1)'(1);
    end

    always_comb begin
        state_d     = state_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SATURATE_EN
        ovf_d       = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    sign_quo_d  = bus.dividend_i[N-1] ^ bus.divisor_i[N-1];
                    sign_rem_d  = bus.dividend_i[N-1];
                    dvd_d       = dividend_abs;
                    dsr_d       = divisor_abs;
                    rem_d       = '0;
                    quo_d       = '0;
                    count_d     = CNT_W'(N - 1);
`ifdef DIV_SATURATE_EN
                    ovf_d       = 1'b0;
`endif
                    // A zero divisor skips the iteration and reports a fixed result.
                    if (bus.divisor_i == '0) begin
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend_i;
                        state_d     = FINISH;
                    end else begin
                        dbz_d       = 1'b0;
                        quotient_d  = '0;
                        remainder_d = '0;
                        state_d     = CALC;
                    end
                end
            end

            CALC: begin
                dvd_d   = dvd_q << 1;
                rem_d   = trial_ok ? trial[N:0] : rem_shift;
                quo_d   = {quo_q[N-1:0], trial_ok};
                count_d = count_q - CNT_W'(1);
                if (count_q == '0) begin
                    state_d = SIGN;
                end
            end

            SIGN: begin
                quotient_d  = sign_quo_q ? quo_neg[N-1:0] : quo_q[N-1:0];
                remainder_d = sign_rem_q ? rem_neg[N-1:0] : rem_q[N-1:0];
`ifdef DIV_SATURATE_EN
                // A positive quotient reaching 2^(N-1) only happens for -2^(N-1) / -1.
                if (!sign_quo_q && quo_q[N-1]) begin
                    quotient_d = {1'b0, {(N-1){1'b1}}};
                    ovf_d      = 1'b1;
                end
`endif
                state_d = FINISH;
            end

            FINISH: begin
                if (bus.enable_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SATURATE_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SATURATE_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Results are only visible while the FSM sits in FINISH.
    always_comb begin
        bus.data_valid_o  = (state_q == FINISH);
        bus.quotient_o    = (state_q == FINISH) ? quotient_q  : '0;
        bus.remainder_o   = (state_q == FINISH) ? remainder_q : '0;
        bus.div_by_zero_o = (state_q == FINISH) ? dbz_q       : 1'b0;
`ifdef DIV_SATURATE_EN
        bus.overflow_o    = (state_q == FINISH) ? ovf_q       : 1'b0;
`endif
    end

endmodule

// File: tb/tb_booth_divide_fsmd.sv
// Directed testbench for booth_divide_fsmd: latency, signs, divide-by-zero, overflow, reset abort.
// Expectations depend on DIV_SATURATE_EN for the -128 / -1 case.
module tb_booth_divide_fsmd;
    logic clk;
    logic reset_i;
    int   compared;
    int   mismatched;

    booth_divide_fsmd_if #(.DATA_SIZE(8)) bus_if ();

    booth_divide_fsmd #(.DATA_SIZE(8)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] dvd, input logic [7:0] dsr);
        bus_if.enable_i   = en;
        bus_if.dividend_i = dvd;
        bus_if.divisor_i  = dsr;
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid, input logic [7:0] exp_q,
                               input logic [7:0] exp_r, input logic exp_dbz, input logic exp_ovf);
        compared++;
        assert (bus_if.data_valid_o === exp_valid) else begin
            mismatched++;
            $error("[TB] FAIL %s data_valid observed=%b expected=%b", tag, bus_if.data_valid_o, exp_valid);
        end
        compared++;
        assert (bus_if.quotient_o === exp_q) else begin
            mismatched++;
            $error("[TB] FAIL %s quotient observed=%h expected=%h", tag, bus_if.quotient_o, exp_q);
        end
        compared++;
        assert (bus_if.remainder_o === exp_r) else begin
            mismatched++;
            $error("[TB] FAIL %s remainder observed=%h expected=%h", tag, bus_if.remainder_o, exp_r);
        end
        compared++;
        assert (bus_if.div_by_zero_o === exp_dbz) else begin
            mismatched++;
            $error("[TB] FAIL %s div_by_zero observed=%b expected=%b", tag, bus_if.div_by_zero_o, exp_dbz);
        end
`ifdef DIV_SATURATE_EN
        compared++;
        assert (bus_if.overflow_o === exp_ovf) else begin
            mismatched++;
            $error("[TB] FAIL %s overflow observed=%b expected=%b", tag, bus_if.overflow_o, exp_ovf);
        end
`else
        if (exp_ovf) $display("[TB] note %s overflow only checked with saturation enabled", tag);
`endif
    endtask

    // Full non-zero-divisor operation: outputs 0 after edges 0..8, result after edge 9, then release.
    task automatic runDivide(input string tag, input logic [7:0] dvd, input logic [7:0] dsr,
                             input logic [7:0] exp_q, input logic [7:0] exp_r, input logic exp_ovf);
        applyStimulus(1'b1, dvd, dsr);
        tick();
        applyStimulus(1'b0, dvd, dsr);
        checkOutput({tag, " edge0"}, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            checkOutput($sformatf("%s edge%0d", tag, e), 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        tick();
        checkOutput({tag, " result"}, 1'b1, exp_q, exp_r, 1'b0, exp_ovf);
        tick();
        checkOutput({tag, " hold"}, 1'b1, exp_q, exp_r, 1'b0, exp_ovf);
        applyStimulus(1'b1, 8'h00, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput({tag, " release"}, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_i    = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00);
        tick();
        tick();
        reset_i = 1'b0;
        checkOutput("reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        runDivide("100/7",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0);
        runDivide("-100/7",  8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0);
        runDivide("100/-7",  8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0);
        runDivide("-100/-7", 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0);

        // Divide by zero finishes right after the start edge.
        applyStimulus(1'b1, 8'd5, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd5, 8'd0);
        checkOutput("5/0 edge0", 1'b1, 8'hFF, 8'h05, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checkOutput($sformatf("5/0 hold%0d", k), 1'b1, 8'hFF, 8'h05, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 8'd5, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0);
        checkOutput("5/0 release", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("5/0 idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

`ifdef DIV_SATURATE_EN
        runDivide("-128/-1", 8'h80, 8'hFF, 8'h7F, 8'h00, 1'b1);
`else
        runDivide("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
`endif
        runDivide("-128/1",  8'h80, 8'h01, 8'h80, 8'h00, 1'b0);

        // Reset asserted at edge 4 of a 100/7 operation.
        applyStimulus(1'b1, 8'd100, 8'd7);
        tick();
        applyStimulus(1'b0, 8'd100, 8'd7);
        tick();
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checkOutput("abort edge4", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput($sformatf("abort idle%0d", k), 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        runDivide("9/3 after abort", 8'd9, 8'd3, 8'h03, 8'h00, 1'b0);

        // Operand changes and enable pulses during CALC must be ignored.
        applyStimulus(1'b1, 8'd127, 8'd10);
        tick();
        applyStimulus(1'b0, 8'hCE, 8'h00);
        checkOutput("127/10 edge0", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            if (e == 2 || e == 4) applyStimulus(1'b1, 8'hCE, 8'h03);
            else                  applyStimulus(1'b0, 8'h11, 8'h00);
            tick();
            checkOutput($sformatf("127/10 edge%0d", e), 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("127/10 result", 1'b1, 8'h0C, 8'h07, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput("127/10 release", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
